// File: rtl/algo_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module   : algo_packet_buffer
// Purpose  : Ping-pong store-and-forward Avalon-ST packet buffer. Inbound
//            packets must be exactly WORDS beats long; anything else is
//            dropped and counted. Complete packets are replayed on the
//            source side through a registered output stage.
// Options  : ALGO_SEQ_HEADER_EN - prepend a {16'hA5A5, seq} header word to
//            every transmitted packet.
// Revision : 1.0 - initial release
// ============================================================================
module algo_packet_buffer #(
  parameter int WORDS = 163,
  parameter int CNT_W = 16
) (
  input  logic             clk_clk,
  input  logic             rst_reset_n,
  input  logic [31:0]      data_in_data,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  input  logic             data_in_startofpacket,
  input  logic             data_in_endofpacket,
  input  logic [1:0]       data_in_empty,
  output logic [31:0]      data_out_data,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             data_out_startofpacket,
  output logic             data_out_endofpacket,
  output logic [1:0]       data_out_empty,
  output logic [CNT_W-1:0] stat_pkt_count,
  output logic [CNT_W-1:0] stat_drop_count
);

  localparam int              AW       = $clog2(WORDS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DROP = 2'd2
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // Both banks share one array; the bank number is the address MSB.
  logic [31:0] mem_q [0:(2**(AW+1))-1];

  rx_state_t       rx_state_q, rx_state_d;
  logic [AW-1:0]   rx_idx_q, rx_idx_d;
  logic [AW-1:0]   wr_idx;
  logic            wr_en;
  logic            commit;
  logic [1:0]      drop_inc;
  logic            en_q;
  logic            wr_bank_q, rd_bank_q;
  logic [1:0]      full_q, full_d;
  logic            in_acc;

  tx_state_t       tx_state_q, tx_state_d;
  logic [AW-1:0]   tx_word_q, tx_word_d;
  logic            tx_more_q, tx_more_d;
  logic            load_en, load, out_fire, rel_pkt;
  logic [31:0]     load_word;
  logic            load_sop, load_eop;
  logic [AW:0]     rd_addr;

  logic [31:0]      dout_q;
  logic             valid_q, sop_q, eop_q;
  logic [CNT_W-1:0] pkt_q, drop_q;

  logic unused_empty;
  assign unused_empty = ^data_in_empty;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Ready is held low until the first edge after reset; in IDLE the target
  // bank must be free, once a packet has started the bank is already ours.
  assign data_in_ready = en_q & ((rx_state_q != RX_IDLE) | ~full_q[wr_bank_q]);
  assign in_acc        = data_in_valid & data_in_ready;

  // RX next-state: packet length checking, bank commit and drop accounting.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    wr_en      = 1'b0;
    wr_idx     = rx_idx_q;
    commit     = 1'b0;
    drop_inc   = 2'd0;
    case (rx_state_q)
      RX_IDLE: begin
        if (in_acc) begin
          if (data_in_startofpacket) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (data_in_endofpacket) begin
              drop_inc = 2'd1;
            end else begin
              rx_idx_d   = AW'(1);
              rx_state_d = RX_RECV;
            end
          end else begin
            drop_inc = 2'd1;
          end
        end
      end
      RX_RECV: begin
        if (in_acc) begin
          wr_en = 1'b1;
          if (data_in_startofpacket) begin
            // Abort the partial packet and restart on this beat.
            wr_idx = '0;
            if (data_in_endofpacket) begin
              drop_inc   = 2'd2;
              rx_state_d = RX_IDLE;
            end else begin
              drop_inc = 2'd1;
              rx_idx_d = AW'(1);
            end
          end else if (data_in_endofpacket) begin
            rx_state_d = RX_IDLE;
            if (rx_idx_q == LAST_IDX) begin
              commit = 1'b1;
            end else begin
              drop_inc = 2'd1;
            end
          end else if (rx_idx_q == LAST_IDX) begin
            rx_state_d = RX_DROP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_DROP: begin
        if (in_acc && data_in_endofpacket) begin
          drop_inc   = 2'd1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Commit and release always target different banks, so both may apply.
  always_comb begin
    full_d = full_q;
    if (commit)  full_d[wr_bank_q] = 1'b1;
    if (rel_pkt) full_d[rd_bank_q] = 1'b0;
  end

  // RX state, bank pointers and full flags.
  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      en_q       <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
    end else begin
      en_q       <= 1'b1;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      full_q     <= full_d;
      if (commit)  wr_bank_q <= ~wr_bank_q;
      if (rel_pkt) rd_bank_q <= ~rd_bank_q;
    end
  end

  // Payload storage; contents are meaningless until a bank is committed.
  always_ff @(posedge clk_clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_idx}] <= data_in_data;
  end

  assign out_fire = valid_q & data_out_ready;
  assign load_en  = ~valid_q | data_out_ready;
  assign rel_pkt  = out_fire & eop_q;
  assign rd_addr  = {rd_bank_q, tx_word_q};

`ifdef ALGO_SEQ_HEADER_EN
  logic        hdr_q, hdr_d;
  logic [15:0] seq_q;
  assign load_word = hdr_q ? {16'hA5A5, seq_q} : mem_q[rd_addr];
  assign load_sop  = hdr_q;
  assign load_eop  = ~hdr_q & (tx_word_q == LAST_IDX);
`else
  assign load_word = mem_q[rd_addr];
  assign load_sop  = (tx_word_q == '0);
  assign load_eop  = (tx_word_q == LAST_IDX);
`endif

  // TX next-state: walk the full bank into the output stage as space allows.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_word_d  = tx_word_q;
    tx_more_d  = tx_more_q;
    load       = 1'b0;
`ifdef ALGO_SEQ_HEADER_EN
    hdr_d      = hdr_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        if (full_q[rd_bank_q]) begin
          tx_state_d = TX_SEND;
          tx_word_d  = '0;
          tx_more_d  = 1'b1;
`ifdef ALGO_SEQ_HEADER_EN
          hdr_d      = 1'b1;
`endif
        end
      end
      TX_SEND: begin
        if (load_en && tx_more_q) begin
          load = 1'b1;
`ifdef ALGO_SEQ_HEADER_EN
          if (hdr_q)                        hdr_d     = 1'b0;
          else if (tx_word_q == LAST_IDX)   tx_more_d = 1'b0;
          else                              tx_word_d = tx_word_q + 1'b1;
`else
          if (tx_word_q == LAST_IDX) tx_more_d = 1'b0;
          else                       tx_word_d = tx_word_q + 1'b1;
`endif
        end
        if (rel_pkt) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state and the registered output stage (synchronous bank read).
  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_word_q  <= '0;
      tx_more_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
`ifdef ALGO_SEQ_HEADER_EN
      hdr_q      <= 1'b0;
      seq_q      <= '0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      tx_more_q  <= tx_more_d;
`ifdef ALGO_SEQ_HEADER_EN
      hdr_q      <= hdr_d;
      if (rel_pkt) seq_q <= seq_q + 16'd1;
`endif
      if (load) begin
        dout_q  <= load_word;
        valid_q <= 1'b1;
        sop_q   <= load_sop;
        eop_q   <= load_eop;
      end else if (data_out_ready) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (rel_pkt)          pkt_q  <= sat_add(pkt_q, 2'd1);
      if (drop_inc != 2'd0) drop_q <= sat_add(drop_q, drop_inc);
    end
  end

  assign data_out_data          = dout_q;
  assign data_out_valid         = valid_q;
  assign data_out_startofpacket = sop_q;
  assign data_out_endofpacket   = eop_q;
  assign data_out_empty         = 2'b00;
  assign stat_pkt_count         = pkt_q;
  assign stat_drop_count        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_algo_packet_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_algo_packet_buffer
// Purpose  : Self-checking bench for algo_packet_buffer with WORDS=4.
//            A packet-level scoreboard predicts the source stream and the
//            status counters; directed tests add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_algo_packet_buffer;
  localparam int WORDS = 4;
  localparam int CNT_W = 16;
  localparam int TMO   = 3000;
`ifdef ALGO_SEQ_HEADER_EN
  localparam int HOFF  = 1;
`else
  localparam int HOFF  = 0;
`endif
  localparam int PKT_LEN = WORDS + HOFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      in_data;
  logic             in_valid, in_sop, in_eop;
  logic [1:0]       in_empty;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid, out_sop, out_eop;
  logic             out_ready;
  logic [1:0]       out_empty;
  logic [CNT_W-1:0] pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  algo_packet_buffer #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk_clk                (clk),
    .rst_reset_n            (rst_n),
    .data_in_data           (in_data),
    .data_in_valid          (in_valid),
    .data_in_ready          (in_ready),
    .data_in_startofpacket  (in_sop),
    .data_in_endofpacket    (in_eop),
    .data_in_empty          (in_empty),
    .data_out_data          (out_data),
    .data_out_valid         (out_valid),
    .data_out_ready         (out_ready),
    .data_out_startofpacket (out_sop),
    .data_out_endofpacket   (out_eop),
    .data_out_empty         (out_empty),
    .stat_pkt_count         (pkt_cnt),
    .stat_drop_count        (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard state: expected {sop, eop, data} stream and counters.
  logic [33:0] exp_q[$];
  logic [31:0] cur[$];
  logic [31:0] olog[$];
  bit          in_pkt;
  int          m_pkt, m_drop;
  logic [15:0] m_seq;
  bit          prev_stall;
  logic [33:0] prev_word;

  int base;
  bit done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level model: a packet is kept only if exactly WORDS beats lie
  // between its SOP and EOP; every other beat sequence counts as one drop.
  task automatic model_beat(input logic [31:0] d, input logic s, input logic e);
    if (s) begin
      if (in_pkt) m_drop++;
      cur.delete();
      cur.push_back(d);
      in_pkt = 1'b1;
    end else if (!in_pkt) begin
      m_drop++;
    end else begin
      cur.push_back(d);
    end
    if (e && in_pkt) begin
      if (cur.size() == WORDS) begin
`ifdef ALGO_SEQ_HEADER_EN
        exp_q.push_back({1'b1, 1'b0, 16'hA5A5, m_seq});
        m_seq++;
        for (int i = 0; i < WORDS; i++) exp_q.push_back({1'b0, (i == WORDS-1), cur[i]});
`else
        for (int i = 0; i < WORDS; i++) exp_q.push_back({(i == 0), (i == WORDS-1), cur[i]});
`endif
      end else begin
        m_drop++;
      end
      in_pkt = 1'b0;
    end
  endtask

  // Compare process: mid-cycle sampling of the state left by the last edge,
  // then record the handshakes that the next edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
      in_pkt     = 1'b0;
      m_pkt      = 0;
      m_drop     = 0;
      m_seq      = 16'd0;
      prev_stall = 1'b0;
    end else begin
      chk("pkt_count", pkt_cnt, m_pkt);
      chk("drop_count", drop_cnt, m_drop);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", {out_sop, out_eop, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        chk("out_empty", out_empty, 2'b00);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %0h expected no beat", out_data);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("out_beat", {out_sop, out_eop, out_data}, e);
          if (e[32]) m_pkt++;
        end
        olog.push_back(out_data);
      end
      prev_stall = out_valid & ~out_ready;
      prev_word  = {out_sop, out_eop, out_data};
      if (in_valid && in_ready) model_beat(in_data, in_sop, in_eop);
    end
  end

  // All driving tasks start and end one time unit after a rising edge.
  task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
    bit acc;
    acc      = 1'b0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    for (int n = 0; n < TMO && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("in_accept", acc, 1'b1);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] first, input int len);
    for (int i = 0; i < len; i++) send_beat(first + 32'(i), (i == 0), (i == len-1));
  endtask

  task automatic wait_drain();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < TMO && !idle; n++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !out_valid;
    end
    repeat (2) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flags", {out_sop, out_eop}, 2'b00);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_counters", {pkt_cnt, drop_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_empty  = 2'b00;
    out_ready = 1'b0;
    done      = 1'b0;

    // Single packet, sink always ready: latency and content.
    do_reset();
    out_ready = 1'b1;
    base = olog.size();
    send_pkt(32'h10, 4);
    @(negedge clk); chk("lat_edge1", out_valid, 1'b0);
    @(negedge clk); chk("lat_edge2", out_valid, 1'b0);
    @(negedge clk); chk("lat_valid", out_valid, 1'b1);
    chk("lat_sop", out_sop, 1'b1);
    wait_drain();
    chk("t1_len", olog.size() - base, PKT_LEN);
`ifdef ALGO_SEQ_HEADER_EN
    chk("t1_hdr", olog[base], 32'hA5A50000);
`endif
    for (int i = 0; i < 4; i++) chk("t1_word", olog[base + HOFF + i], 32'h10 + 32'(i));
    chk("t1_pkt", pkt_cnt, 1);

    // Three packets against a stalled sink: third SOP must wait.
    do_reset();
    out_ready = 1'b0;
    base = olog.size();
    send_pkt(32'h20, 4);
    send_pkt(32'h30, 4);
    in_data  = 32'h40;
    in_sop   = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_ready_low", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    fork
      send_pkt(32'h40, 4);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t2_len", olog.size() - base, 3 * PKT_LEN);
    chk("t2_first", olog[base + HOFF], 32'h20);
    chk("t2_third", olog[base + 2*PKT_LEN + HOFF], 32'h40);
`ifdef ALGO_SEQ_HEADER_EN
    chk("t2_hdr0", olog[base], 32'hA5A50000);
    chk("t2_hdr1", olog[base + PKT_LEN], 32'hA5A50001);
`endif
    chk("t2_pkt", pkt_cnt, 3);
    chk("t2_drop", drop_cnt, 0);

    // Short and long packets are dropped, a following good one passes.
    do_reset();
    base = olog.size();
    send_pkt(32'h50, 3);
    chk("t3_drop_short", drop_cnt, 1);
    send_pkt(32'h60, 6);
    chk("t3_drop_long", drop_cnt, 2);
    send_pkt(32'h70, 4);
    wait_drain();
    chk("t3_len", olog.size() - base, PKT_LEN);
    chk("t3_word0", olog[base + HOFF], 32'h70);
    chk("t3_word3", olog[base + HOFF + 3], 32'h73);
    chk("t3_pkt", pkt_cnt, 1);

    // SOP at index 2 restarts the packet.
    do_reset();
    base = olog.size();
    send_beat(32'h80, 1'b1, 1'b0);
    send_beat(32'h81, 1'b0, 1'b0);
    send_pkt(32'h90, 4);
    wait_drain();
    chk("t4_drop", drop_cnt, 1);
    chk("t4_pkt", pkt_cnt, 1);
    chk("t4_word0", olog[base + HOFF], 32'h90);
    chk("t4_word3", olog[base + HOFF + 3], 32'h93);

    // 100 random packets with random source backpressure and input gaps.
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          for (int i = 0; i < WORDS; i++) begin
            send_beat($urandom, (i == 0), (i == WORDS-1));
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("t5_pkt", pkt_cnt, 100);
    chk("t5_drop", drop_cnt, 0);

    // Reset in the middle of a transmission.
    out_ready = 1'b0;
    send_pkt(32'hA0, 4);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("t6_valid_seen", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_data", out_data, 32'h0);
    chk("t6_flags", {out_sop, out_eop}, 2'b00);
    chk("t6_counters", {pkt_cnt, drop_cnt}, 32'h0);
    chk("t6_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); chk("t6_ready_hold", in_ready, 1'b0);
    @(negedge clk); chk("t6_ready_rise", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = olog.size();
    send_pkt(32'hB0, 4);
    wait_drain();
    chk("t6_len", olog.size() - base, PKT_LEN);
    chk("t6_word0", olog[base + HOFF], 32'hB0);
    chk("t6_pkt", pkt_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/algo_packet_buffer.md
# algo_packet_buffer

Parametrised store-and-forward packet buffer for Avalon-ST. It sits between the sensor interface and the UDP packet generator. Two ping-pong banks let the next packet be received while the previous one is transmitted. Every inbound packet is checked against the configured length; malformed packets are dropped and counted, and only complete packets reach the output.

## Interface
Parameters:
- WORDS, 163, 32-bit words per valid packet (≥2).
- CNT_W, 16, width of status counters.

Ports. One clock; reset is synchronous and active-low.
- clk_clk  in  1  system clock; all logic on the rising edge.
- rst_reset_n  in  1  synchronous active-low reset.
- data_in_data  in  32  sink data.
- data_in_valid  in  1  sink valid.
- data_in_ready  out  1  sink ready.
- data_in_startofpacket  in  1  sink SOP.
- data_in_endofpacket  in  1  sink EOP.
- data_in_empty  in  2  ignored; words are always full.
- data_out_data  out  32  source data.
- data_out_valid  out  1  source valid.
- data_out_ready  in  1  source ready.
- data_out_startofpacket  out  1  source SOP.
- data_out_endofpacket  out  1  source EOP.
- data_out_empty  out  2  constant 2'b00.
- stat_pkt_count  out  CNT_W  packets fully transmitted; saturates.
- stat_drop_count  out  CNT_W  packets or stray beats dropped; saturates.

## Operation
- Storage is two banks of WORDS × 32 bits, with a bank full flag for each. wr_bank and rd_bank each toggle 0 and 1.
- A beat is accepted when data_in_valid & data_in_ready. data_out_empty is always 0.
- RX state machine:
  - RX_IDLE:
    - ready = (full[wr_bank] == 0).
    - Accepted beat with SOP: store at index 0, set rx_idx=1, go to RX_RECV. If this beat also has EOP, it is a drop (length 1 < WORDS); stay in RX_IDLE.
    - Accepted beat without SOP: discard, drop_count+1.
  - RX_RECV:
    - ready = 1; the bank is already reserved.
    - Store at rx_idx and increment rx_idx.
    - EOP on index WORDS-1: set full[wr_bank], toggle wr_bank, go to RX_IDLE.
    - EOP on an index below WORDS-1: discard, drop_count+1, go to RX_IDLE; the bank is not committed.
    - SOP mid-packet: abort the current packet, drop_count+1, and restart with this beat as index 0.
    - Index WORDS-1 accepted without EOP: go to RX_DROP.
  - RX_DROP:
    - ready = 1; consume beats until EOP.
    - On EOP: drop_count+1, go to RX_IDLE.
- TX state machine:
  - TX_IDLE: when full[rd_bank], go to TX_SEND with tx_idx=0.
  - TX_SEND:
    - A registered output stage is loaded from the synchronous bank read whenever (!data_out_valid | data_out_ready).
    - SOP is set on word 0; EOP is set on the last word.
    - When the last word is accepted: clear full[rd_bank], toggle rd_bank, pkt_count+1, go to TX_IDLE.
- If commit (set full) and release (clear full) hit the same cycle, both take effect; they always target different banks.
- Counters saturate at 2^CNT_W-1. They never wrap.

## Timing
- Reset (rst_reset_n low at an edge):
  - data_in_ready=0, data_out_valid=0, SOP=0, EOP=0, data_out_data=0, both counters 0.
  - Both banks empty, wr_bank=rd_bank=0, both FSMs idle.
  - A packet in flight is discarded and not counted.
  - data_in_ready rises on the first edge after release.
- Latency: EOP of a valid packet is accepted at edge N, and data_out_valid with SOP is high after edge N+2.
- With data_out_ready held high, the output delivers one word per cycle with no bubbles.
- Backpressure: data_out_data and the packet flags stay stable while valid is high and ready is low.
- With both banks full, data_in_ready stays low in RX_IDLE. It rises the cycle after the last TX word is accepted.
- Dropped beats never reach the source.

## Configuration
- ALGO_SEQ_HEADER_EN defined:
  - The transmitter prepends one header word {16'hA5A5, seq[15:0]}, carrying SOP, and emits WORDS+1 words per packet.
  - seq starts at 0 after reset and increments per transmitted packet, wrapping 0xFFFF→0.
  - Latency is unchanged; the header appears at N+2.
- ALGO_SEQ_HEADER_EN undefined: exactly WORDS words per packet, with no header logic.

## Test plan
- WORDS=4, one packet 0x10..0x13 with SOP/EOP, ready=1 -> output 0x10..0x13 with SOP on 0x10 and EOP on 0x13; valid first seen 2 cycles after the input EOP; stat_pkt_count=1.
- WORDS=4, three back-to-back packets with data_out_ready=0 -> the first two are accepted and data_in_ready drops during the third SOP. Releasing ready yields all three in order, with pkt_count=3 and drop_count=0.
- WORDS=4:
  - 3-word packet (early EOP) -> dropped, drop_count=1.
  - 6-word packet -> dropped, drop_count=2; the following valid packet passes intact.
- WORDS=4, SOP at index 2 followed by a valid 4-word body -> drop_count=1, and the restarted packet is output correctly.
- Random ready toggling (50%) over 100 packets -> no data corruption, flags stable under stall, pkt_count=100. Reset pulsed mid-transmission -> outputs 0 the next cycle and counters 0.
- With ALGO_SEQ_HEADER_EN, two packets -> headers 0xA5A50000 and 0xA5A50001, each packet 5 words long.
